// File: rtl/s_axi_write_gen2_pkg.sv
// Shared constants and FSM state type for the gen2 AXI4-Lite write slave.
// Bank select codes, response codes and register/field offsets used by decoders and banks.
package s_axi_gen2_pkg;

  localparam logic [1:0] BANK0_SEL   = 2'b00;
  localparam logic [1:0] BANK1_SEL   = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bank1 slot-table field offsets (addr[5:2])
  localparam int SRC_ADDR = 0;
  localparam int DST_ADDR = 1;
  localparam int SIZE     = 2;
  localparam int MODE     = 3;
  localparam int TRIGGER  = 4;
  localparam int PROFILE  = 5;

  // Bank0 register offsets (addr[13:6])
  localparam int CONTROL  = 0;
  localparam int END_CNT  = 3;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } wr_state_e;

endpackage

// File: rtl/s_axi_write_gen2_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) with master and slave views.
import s_axi_gen2_pkg::*;

interface s_axi_write_gen2_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/s_axi_wr_addr_decode.sv
// Combinational address decode: maps addr/strb/busy to one-hot bank strobes and a response.
// Optional macro SEQ_WRITE_PROTECT_EN blocks bank1 writes while the sequencer is busy.
module s_axi_wr_addr_decode
  import s_axi_gen2_pkg::*;
#(
  parameter int STRB_WIDTH        = 4,
  parameter int BANK1_INDEX_WIDTH = 2,
  parameter int BANK1_NUM_FIELDS  = 6,
  parameter int BANK0_NUM_REGS    = 4
) (
  input  logic [15:0]                 addr,
  input  logic [STRB_WIDTH-1:0]       strb,
  input  logic                        busy,
  output logic [BANK0_NUM_REGS-1:0]   bank0_set,
  output logic [BANK1_NUM_FIELDS-1:0] bank1_set,
  output logic [1:0]                  resp
);

  logic [1:0]                     bank;
  logic [7:0]                     reg_idx;
  logic [3:0]                     field;
  logic [7-BANK1_INDEX_WIDTH:0]   slot_hi;
  logic                           strb_any;
  logic                           bank1_allow;
  logic                           addr_lsb_unused;

  assign bank            = addr[15:14];
  assign reg_idx         = addr[13:6];
  assign field           = addr[5:2];
  assign slot_hi         = addr[13:6+BANK1_INDEX_WIDTH];
  assign strb_any        = |strb;
  assign addr_lsb_unused = ^addr[1:0];

`ifdef SEQ_WRITE_PROTECT_EN
  // Bank0 stays writable so software can still stop a running sequencer.
  assign bank1_allow = !busy;
`else
  logic busy_unused;
  assign busy_unused = busy;
  assign bank1_allow = 1'b1;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bank0_set = '0;
    bank1_set = '0;
    resp      = RESP_SLVERR;
    if (bank == BANK0_SEL) begin
      if (int'(reg_idx) < BANK0_NUM_REGS) begin
        resp = RESP_OKAY;
        for (int i = 0; i < BANK0_NUM_REGS; i++)
          bank0_set[i] = strb_any && (int'(reg_idx) == i);
      end
    end else if (bank == BANK1_SEL) begin
      if (slot_hi == '0 && int'(field) < BANK1_NUM_FIELDS && bank1_allow) begin
        resp = RESP_OKAY;
        for (int i = 0; i < BANK1_NUM_FIELDS; i++)
          bank1_set[i] = strb_any && (int'(field) == i);
      end
    end
  end

endmodule

// File: rtl/s_axi_write_gen2.sv
// Gen2 AXI4-Lite write slave for the DFX sequencer register file: AW/W holds, 3-state FSM,
// one-cycle set strobes. Optional macro SEQ_WRITE_PROTECT_EN (handled in the decoder).
module s_axi_write_gen2
  import s_axi_gen2_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int BANK1_INDEX_WIDTH = 2,
  parameter int BANK1_NUM_FIELDS  = 6,
  parameter int BANK0_NUM_REGS    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  s_axi_write_gen2_if.slave             axi,
  input  logic                          seq_busy,
  output logic [DATA_WIDTH-1:0]         ext_wr_data,
  output logic [DATA_WIDTH/8-1:0]       ext_wr_strb,
  output logic [BANK1_INDEX_WIDTH-1:0]  ext_bank1_index,
  output logic [BANK1_NUM_FIELDS-1:0]   ext_bank1_set,
  output logic [BANK0_NUM_REGS-1:0]     ext_bank0_set
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_e               state_q, state_d;
  logic                    aw_full_q, aw_full_d;
  logic [15:0]             aw_addr_q, aw_addr_d;
  logic                    w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_d;
  logic [1:0]              bresp_q, bresp_d;

  logic                        awready, wready;
  logic [BANK0_NUM_REGS-1:0]   dec_bank0_set;
  logic [BANK1_NUM_FIELDS-1:0] dec_bank1_set;
  logic [1:0]                  dec_resp;

  if (ADDR_WIDTH > 16) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^axi.S_AXI_AWADDR[ADDR_WIDTH-1:16];
  end

  // Ready depends only on registered state; reset forces every output low.
  assign awready = !reset && state_q == ACCEPT && !aw_full_q;
  assign wready  = !reset && state_q == ACCEPT && !w_full_q;

  s_axi_wr_addr_decode #(
    .STRB_WIDTH        (STRB_WIDTH),
    .BANK1_INDEX_WIDTH (BANK1_INDEX_WIDTH),
    .BANK1_NUM_FIELDS  (BANK1_NUM_FIELDS),
    .BANK0_NUM_REGS    (BANK0_NUM_REGS)
  ) u_decode (
    .addr      (aw_addr_q),
    .strb      (w_strb_q),
    .busy      (seq_busy),
    .bank0_set (dec_bank0_set),
    .bank1_set (dec_bank1_set),
    .resp      (dec_resp)
  );

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    unique case (state_q)
      ACCEPT: begin
        if (axi.S_AXI_AWVALID && awready) begin
          aw_full_d = 1'b1;
          aw_addr_d = axi.S_AXI_AWADDR[15:0];
        end
        if (axi.S_AXI_WVALID && wready) begin
          w_full_d = 1'b1;
          w_data_d = axi.S_AXI_WDATA;
          w_strb_d = axi.S_AXI_WSTRB;
        end
        if (aw_full_d && w_full_d) state_d = COMMIT;
      end
      COMMIT: begin
        bresp_d = dec_resp;
        state_d = RESP;
      end
      RESP: begin
        if (axi.S_AXI_BREADY) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCEPT;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign axi.S_AXI_AWREADY = awready;
  assign axi.S_AXI_WREADY  = wready;
  assign axi.S_AXI_BVALID  = !reset && state_q == RESP;
  assign axi.S_AXI_BRESP   = reset ? 2'b00 : bresp_q;

  assign ext_bank0_set   = (!reset && state_q == COMMIT) ? dec_bank0_set : '0;
  assign ext_bank1_set   = (!reset && state_q == COMMIT) ? dec_bank1_set : '0;
  assign ext_wr_data     = reset ? '0 : w_data_q;
  assign ext_wr_strb     = reset ? '0 : w_strb_q;
  assign ext_bank1_index = reset ? '0 : aw_addr_q[6 +: BANK1_INDEX_WIDTH];

endmodule

// File: tb/tb_s_axi_write_gen2.sv
// Directed bench for s_axi_write_gen2: vector table of single writes plus hand-written
// sequences for split channels, BREADY backpressure, mid-transaction reset and write protect.
module tb_s_axi_write_gen2;
  import s_axi_gen2_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       seq_busy;
  logic [31:0] ext_wr_data;
  logic [3:0]  ext_wr_strb;
  logic [1:0]  ext_bank1_index;
  logic [5:0]  ext_bank1_set;
  logic [3:0]  ext_bank0_set;

  int checks = 0;
  int errors = 0;

  s_axi_write_gen2_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

  s_axi_write_gen2 #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .BANK1_INDEX_WIDTH(2),
    .BANK1_NUM_FIELDS(6), .BANK0_NUM_REGS(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .axi             (axi),
    .seq_busy        (seq_busy),
    .ext_wr_data     (ext_wr_data),
    .ext_wr_strb     (ext_wr_strb),
    .ext_bank1_index (ext_bank1_index),
    .ext_bank1_set   (ext_bank1_set),
    .ext_bank0_set   (ext_bank0_set)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  exp_b0;
    logic [5:0]  exp_b1;
    logic [1:0]  exp_idx;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Same-cycle AW+W write with BREADY high; checks pulse at N+1 and response at N+2.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    axi.S_AXI_AWADDR  = v.addr;
    axi.S_AXI_WDATA   = v.data;
    axi.S_AXI_WSTRB   = v.strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b1;
    check({tag, "_ready"}, {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check({tag, "_b0set"}, ext_bank0_set, v.exp_b0);
    check({tag, "_b1set"}, ext_bank1_set, v.exp_b1);
    check({tag, "_bvalid_n1"}, axi.S_AXI_BVALID, 1'b0);
    if (v.exp_b0 != 0 || v.exp_b1 != 0) begin
      check({tag, "_wdata"}, ext_wr_data, v.data);
      check({tag, "_wstrb"}, ext_wr_strb, v.strb);
    end
    if (v.exp_b1 != 0) check({tag, "_index"}, ext_bank1_index, v.exp_idx);
    @(negedge clk);
    check({tag, "_bvalid_n2"}, axi.S_AXI_BVALID, 1'b1);
    check({tag, "_bresp"}, axi.S_AXI_BRESP, v.exp_resp);
    check({tag, "_noset_n2"}, {ext_bank0_set, ext_bank1_set}, 10'b0);
    @(negedge clk);
    check({tag, "_bvalid_done"}, axi.S_AXI_BVALID, 1'b0);
    check({tag, "_ready_again"}, {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset             = 1'b1;
    seq_busy          = 1'b0;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;

    vecs[0]  = '{16'h4048, 32'hDEADBEEF, 4'hF, 4'b0000, 6'b000100, 2'd1, RESP_OKAY};
    vecs[1]  = '{16'h0000, 32'h11111111, 4'hF, 4'b0001, 6'b000000, 2'd0, RESP_OKAY};
    vecs[2]  = '{16'h00C0, 32'h00000002, 4'hF, 4'b1000, 6'b000000, 2'd0, RESP_OKAY};
    vecs[3]  = '{16'h8000, 32'hAAAA5555, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
    vecs[4]  = '{16'h4018, 32'h0BADF00D, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
    vecs[5]  = '{16'h0100, 32'h00000004, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
    vecs[6]  = '{16'h40D4, 32'h12345678, 4'h3, 4'b0000, 6'b100000, 2'd3, RESP_OKAY};
    vecs[7]  = '{16'h4114, 32'h87654321, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
    vecs[8]  = '{16'h0040, 32'hFFFFFFFF, 4'h0, 4'b0000, 6'b000000, 2'd0, RESP_OKAY};
    vecs[9]  = '{16'hC040, 32'h00000001, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
    vecs[10] = '{16'h0043, 32'hCAFEBABE, 4'h8, 4'b0010, 6'b000000, 2'd0, RESP_OKAY};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
                          ext_bank0_set, ext_bank1_set}, 13'b0);
    check("rst_bresp", axi.S_AXI_BRESP, 2'b00);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // W first, AW three cycles later
    @(negedge clk);
    axi.S_AXI_WDATA  = 32'h00000002;
    axi.S_AXI_WSTRB  = 4'hF;
    axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    check("split_wready_low", axi.S_AXI_WREADY, 1'b0);
    check("split_awready_high", axi.S_AXI_AWREADY, 1'b1);
    check("split_noset_early", {ext_bank0_set, ext_bank1_set}, 10'b0);
    @(negedge clk);
    @(negedge clk);
    check("split_still_waiting", {axi.S_AXI_WREADY, axi.S_AXI_BVALID, ext_bank0_set}, 6'b0);
    axi.S_AXI_AWADDR  = 16'h00C0;
    axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("split_b0set", ext_bank0_set, 4'b1000);
    check("split_wdata", ext_wr_data, 32'h00000002);
    @(negedge clk);
    check("split_bvalid", axi.S_AXI_BVALID, 1'b1);
    check("split_bresp", axi.S_AXI_BRESP, RESP_OKAY);
    @(negedge clk);
    check("split_done", {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 3'b011);

    // BREADY held low for five cycles on an SLVERR response
    @(negedge clk);
    axi.S_AXI_AWADDR  = 16'h8000;
    axi.S_AXI_WDATA   = 32'h5A5A5A5A;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b0;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("bp_noset", {ext_bank0_set, ext_bank1_set}, 10'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k),
            {axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY, axi.S_AXI_WREADY},
            {1'b1, RESP_SLVERR, 2'b00});
      @(negedge clk);
    end
    check("bp_last", {axi.S_AXI_BVALID, axi.S_AXI_BRESP}, {1'b1, RESP_SLVERR});
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    check("bp_release", {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 3'b011);

    // Reset while in COMMIT
    @(negedge clk);
    axi.S_AXI_AWADDR  = 16'h0000;
    axi.S_AXI_WDATA   = 32'h00000001;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_commit_noset", {ext_bank0_set, ext_bank1_set}, 10'b0);
    @(negedge clk);
    check("rst_commit_bvalid", axi.S_AXI_BVALID, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_commit_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);
    @(negedge clk);
    check("rst_commit_quiet", {axi.S_AXI_BVALID, ext_bank0_set, ext_bank1_set}, 11'b0);

    // Reset while in RESP
    @(negedge clk);
    axi.S_AXI_AWADDR  = 16'h4000;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b0;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    check("rst_resp_pre_bvalid", axi.S_AXI_BVALID, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_resp_bvalid", axi.S_AXI_BVALID, 1'b0);
    reset = 1'b0;
    axi.S_AXI_BREADY = 1'b1;
    #1;
    check("rst_resp_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID}, 3'b110);
    run_vec(vecs[0], "post_rst");

    // Sequencer write protect
    seq_busy = 1'b1;
`ifdef SEQ_WRITE_PROTECT_EN
    v = '{16'h4000, 32'h00000077, 4'hF, 4'b0000, 6'b000000, 2'd0, RESP_SLVERR};
`else
    v = '{16'h4000, 32'h00000077, 4'hF, 4'b0000, 6'b000001, 2'd0, RESP_OKAY};
`endif
    run_vec(v, "busy_b1");
    v = '{16'h0000, 32'h00000001, 4'hF, 4'b0001, 6'b000000, 2'd0, RESP_OKAY};
    run_vec(v, "busy_b0");
    seq_busy = 1'b0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_axi_write_gen2.md
Name: s_axi_write_gen2

Overview:
Second-generation AXI4-Lite write slave for the DFX sequencer register file. It accepts AW and W independently, in either order or in the same cycle. It decodes the address into bank0 control registers and bank1 slot-table fields and emits one-cycle set strobes with write data and byte strobes. Unmapped addresses complete with SLVERR and produce no strobe. It sits between the PS AXI-Lite interconnect and the bank0/bank1 register banks.

Parameters:
ADDR_WIDTH, 16, AXI address width; must be ≥ 16.
DATA_WIDTH, 32, AXI data width (32 or 64).
BANK1_INDEX_WIDTH, 2, slot index bits; 2^N slots.
BANK1_NUM_FIELDS, 6, fields per slot; field = addr[5:2]; must be ≤ 16.
BANK0_NUM_REGS, 4, bank0 registers; reg = addr[13:6]; must be ≤ 256.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  address valid
S_AXI_AWREADY  out  1  address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  data valid
S_AXI_WREADY  out  1  data ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response ready
seq_busy  in  1  sequencer running; used only with the optional feature
ext_wr_data  out  DATA_WIDTH  captured write data, valid during set pulses
ext_wr_strb  out  DATA_WIDTH/8  captured WSTRB
ext_bank1_index  out  BANK1_INDEX_WIDTH  slot index = addr[6+BANK1_INDEX_WIDTH-1:6]
ext_bank1_set  out  BANK1_NUM_FIELDS  one-hot field write pulse
ext_bank0_set  out  BANK0_NUM_REGS  one-hot bank0 register write pulse (bit 0 control, bit 3 endCnt)

Behaviour:
- Reset: synchronous, active-high, on clk. All state cleared; all outputs 0.
- Holding registers: aw_hold (addr + full flag) and w_hold (data, strb + full flag).
- AWREADY = !aw_full && state==ACCEPT.
- WREADY = !w_full && state==ACCEPT.
- Both ready signals are combinational from registers only, never from the VALID inputs.
- FSM states:
  - ACCEPT: capture whichever channel handshakes. When both holds are full (including same-cycle capture), go to COMMIT on the next edge.
  - COMMIT: exactly one cycle. Decode; assert at most one set bit; latch bresp.
  - RESP: BVALID=1 and BRESP stable until BVALID&&BREADY. At the handshake, clear both holds and return to ACCEPT, so AWREADY/WREADY are high the next cycle.
- Latency: AW and W both accepted at edge N → set pulse during cycle N+1 → BVALID from cycle N+2. Back-to-back minimum is 3 cycles per write when BREADY=1.
- Decode in COMMIT, with bank = addr[15:14]:
  - bank 00: if addr[13:6] < BANK0_NUM_REGS, ext_bank0_set[addr[13:6]]=1 and resp OKAY. Otherwise resp SLVERR.
  - bank 01: if addr[13:6+BANK1_INDEX_WIDTH]==0 and addr[5:2] < BANK1_NUM_FIELDS, ext_bank1_set[addr[5:2]]=1 and resp OKAY. Otherwise resp SLVERR.
  - bank 10/11: resp SLVERR.
- addr[1:0] and address bits above bit 15 are ignored.
- WSTRB==0: no set pulse, resp OKAY.
- Otherwise WSTRB is passed through unchanged; banks apply byte masking.
- ext_wr_data, ext_wr_strb and ext_bank1_index are driven from the holds. They are meaningful only while a set bit is high.
- Reset mid-operation: holds, pending response and BVALID are dropped immediately. A transaction in flight is lost, with no pulse. The master must also be reset.

Optional Feature:
SEQ_WRITE_PROTECT_EN
- Defined: in COMMIT, if seq_busy==1 and bank==01, no set pulse is issued and resp is SLVERR. Bank0 writes are still allowed, so the sequencer can be stopped.
- Undefined: seq_busy is ignored; the port remains and is unused.

Decomposition:
- Package s_axi_gen2_pkg holds:
  - BANK0_SEL=2'b00, BANK1_SEL=2'b01;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - field offsets SRC_ADDR=0 .. PROFILE=5, bank0 CONTROL=0, END_CNT=3;
  - FSM state enum {ACCEPT, COMMIT, RESP}.
- One sub-module, s_axi_wr_addr_decode: purely combinational. It maps addr, strb and busy to set vectors and resp. It is reused by a future read-path generation.

Test Plan:
1. AW 0x4048 and W 0xDEADBEEF (strb F) in the same cycle → ext_bank1_index=1, ext_bank1_set=6'b000100 for one cycle at N+1, ext_wr_data=DEADBEEF; BVALID at N+2 with BRESP=00.
2. W first, AW 3 cycles later to 0x00C0 with data 2 → WREADY low after capture; ext_bank0_set=4'b1000 one cycle after AW; BRESP=00.
3. AW 0x8000, and separately AW 0x4018 (field 6) → no set pulse; BRESP=10 for each.
4. BREADY held low 5 cycles → BVALID and BRESP stable; AWREADY/WREADY low throughout; both go high the cycle after the handshake.
5. reset asserted in COMMIT and in RESP → no set pulse; BVALID=0 next cycle; AWREADY=1 after reset deasserts.
6. With SEQ_WRITE_PROTECT_EN and seq_busy=1: write to 0x4000 → no pulse, BRESP=10; write to 0x0000 → ext_bank0_set[0] pulses, BRESP=00.
